// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types, default widths and saturation limit helpers
//                for the Booth product dot-accumulator.
//  Revision    : 1.0  initial release
// ============================================================================
package booth_pkg;

    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } acc_state_t;

    // Largest positive two's complement value of width w (in the low w bits).
    function automatic logic [63:0] acc_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value of width w (in the low w bits).
    function automatic logic [63:0] acc_min(input int w);
        return ~acc_max(w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/booth_dot_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module      : booth_dot_accumulator_if
//  Description : Product input / result output handshake bundle for the
//                dot-accumulator. master = producer+consumer side,
//                slave = accumulator side.
//  Revision    : 1.0  initial release
// ============================================================================
interface booth_dot_accumulator_if
    import booth_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
) ();

    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;
    logic              busy;

    modport master (
        output start, in_valid, in_prod, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, busy
    );

    modport slave (
        input  start, in_valid, in_prod, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, busy
    );

endinterface
`default_nettype wire

// File: rtl/booth_dot_accumulator_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : acc_sat_add
//  Description : Combinational signed adder with overflow flag. With macro
//                ACC_SAT_EN defined the sum clamps to the signed limit on
//                overflow; otherwise it wraps modulo 2^ACC_W.
//  Revision    : 1.0  initial release
// ============================================================================
module acc_sat_add
    import booth_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  wire logic [ACC_W-1:0] i_a,
    input  wire logic [ACC_W-1:0] i_b,
    output logic      [ACC_W-1:0] o_sum,
    output logic                  o_ovf
);

    logic [ACC_W-1:0] w_raw;

    assign w_raw = i_a + i_b;

    // Overflow when both operands share a sign the raw result does not.
    always_comb begin
        o_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);
`ifdef ACC_SAT_EN
        if (o_ovf) begin
            o_sum = i_a[ACC_W-1] ? ACC_W'(acc_min(ACC_W)) : ACC_W'(acc_max(ACC_W));
        end else begin
            o_sum = w_raw;
        end
`else
        o_sum = w_raw;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/booth_dot_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : booth_dot_accumulator
//  Description : Sums TERMS signed products (valid/ready in) into one signed
//                result (valid/ready out) with a sticky overflow flag.
//                Optional clamping on overflow via macro ACC_SAT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module booth_dot_accumulator
    import booth_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int TERMS  = 4
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    booth_dot_accumulator_if.slave   bus
);

    localparam int CNT_W = $clog2(TERMS + 1);

    acc_state_t       r_state;
    acc_state_t       w_state_nxt;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic [ACC_W-1:0] r_out_acc;
    logic             r_out_ovf;

    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_add_ovf;
    logic             w_last;
    logic             w_clear;
    logic             w_accept;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    assign w_prod_ext = ACC_W'($signed(bus.in_prod));
    assign w_last     = (r_cnt == CNT_W'(TERMS - 1));

    acc_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .i_a   (r_acc),
        .i_b   (w_prod_ext),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, handshake outputs and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b0;
        w_clear     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ACC;
                    w_clear     = 1'b1;
                end
            end
            ACC: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b1;
                w_accept   = bus.in_valid;
                if (bus.in_valid && w_last) begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                w_out_valid = 1'b1;
                w_busy      = 1'b1;
                if (bus.out_ready) begin
                    // A start alongside the result handshake skips IDLE.
                    if (bus.start) begin
                        w_state_nxt = ACC;
                        w_clear     = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Accumulator, term counter, sticky overflow and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_out_acc <= '0;
            r_out_ovf <= 1'b0;
        end else if (w_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_W'(1);
            r_ovf <= r_ovf | w_add_ovf;
            if (w_last) begin
                r_out_acc <= w_sum;
                r_out_ovf <= r_ovf | w_add_ovf;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.out_acc   = r_out_acc;
    assign bus.out_ovf   = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_booth_dot_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_dot_accumulator
//  Description : Scoreboard bench for booth_dot_accumulator. Instance A uses
//                ACC_W=24/TERMS=4, instance B uses ACC_W=16/TERMS=2 for the
//                overflow cases (expectations follow macro ACC_SAT_EN).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_booth_dot_accumulator;

    typedef struct {
        logic [23:0] acc;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;

    int errors;
    int checks;

    exp_t sb_a[$];
    exp_t sb_b[$];

    booth_dot_accumulator_if #(.PROD_W(16), .ACC_W(24)) bus_a ();
    booth_dot_accumulator_if #(.PROD_W(16), .ACC_W(16)) bus_b ();

    booth_dot_accumulator #(.PROD_W(16), .ACC_W(24), .TERMS(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    booth_dot_accumulator #(.PROD_W(16), .ACC_W(16), .TERMS(2)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] a24(input int v);
        return v[23:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a result handshake is about to happen.
    always @(negedge clk) begin
        if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
            if (sb_a.size() == 0) begin
                chk("a_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_a.pop_front();
                chk("a_out_acc", {8'b0, bus_a.out_acc}, {8'b0, e.acc});
                chk("a_out_ovf", {31'b0, bus_a.out_ovf}, {31'b0, e.ovf});
            end
        end
        if (rst_n && bus_b.out_valid && bus_b.out_ready) begin
            if (sb_b.size() == 0) begin
                chk("b_unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_b.pop_front();
                chk("b_out_acc", {16'b0, bus_b.out_acc}, {8'b0, e.acc});
                chk("b_out_ovf", {31'b0, bus_b.out_ovf}, {31'b0, e.ovf});
            end
        end
    end

    task automatic start_a();
        bus_a.start = 1'b1;
        @(posedge clk); #1;
        bus_a.start = 1'b0;
    endtask

    task automatic send_a(input int v);
        bit ok;
        ok = 1'b0;
        bus_a.in_valid = 1'b1;
        bus_a.in_prod  = 16'(v);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("a_in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic run_b(input int v0, input int v1, input int ea, input bit eo);
        sb_b.push_back(exp_t'{a24(ea), eo});
        bus_b.start = 1'b1;
        @(posedge clk); #1;
        bus_b.start    = 1'b0;
        bus_b.in_valid = 1'b1;
        bus_b.in_prod  = 16'(v0);
        @(posedge clk); #1;
        bus_b.in_prod  = 16'(v1);
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        chk("b_latency_valid", {31'b0, bus_b.out_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus_a.start = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_prod = '0; bus_a.out_ready = 1'b0;
        bus_b.start = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_prod = '0; bus_b.out_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'b0, bus_a.in_ready},  32'd0);
        chk("rst_busy",      {31'b0, bus_a.busy},      32'd0);
        chk("rst_out_acc",   {8'b0, bus_a.out_acc},    32'd0);
        chk("rst_out_ovf",   {31'b0, bus_a.out_ovf},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 16-bit accumulator overflow cases, then a clean sequence.
`ifdef ACC_SAT_EN
        run_b(32'h7FFF, 32'h7FFF, 32'h7FFF, 1'b1);
        run_b(32'h8000, 32'h8000, 32'h8000, 1'b1);
`else
        run_b(32'h7FFF, 32'h7FFF, 32'hFFFE, 1'b1);
        run_b(32'h8000, 32'h8000, 32'h0000, 1'b1);
`endif
        run_b(3, -5, 32'hFFFE, 1'b0);

        // Basic sum with result held 5 cycles under back-pressure.
        sb_a.push_back(exp_t'{a24(60), 1'b0});
        start_a();
        chk("a_busy_after_start", {31'b0, bus_a.busy}, 32'd1);
        send_a(100);
        send_a(-50);
        send_a(7);
        send_a(3);
        chk("a_latency_valid", {31'b0, bus_a.out_valid}, 32'd1);
        bus_a.in_valid = 1'b1;
        bus_a.in_prod  = 16'd999;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_in_ready",  {31'b0, bus_a.in_ready},  32'd0);
            chk("hold_out_valid", {31'b0, bus_a.out_valid}, 32'd1);
            chk("hold_out_acc",   {8'b0, bus_a.out_acc},    32'd60);
            @(posedge clk); #1;
        end
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        chk("idle_busy",      {31'b0, bus_a.busy},    32'd0);
        chk("retain_out_acc", {8'b0, bus_a.out_acc},  32'd60);

        // Gaps between valid products; only accepted ones count.
        sb_a.push_back(exp_t'{a24(1016), 1'b0});
        start_a();
        send_a(5);
        repeat (2) @(posedge clk);
        #1;
        send_a(-9);
        @(posedge clk); #1;
        send_a(20);
        chk("gap_not_done", {31'b0, bus_a.out_valid}, 32'd0);
        bus_a.out_ready = 1'b1;
        send_a(1000);
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;

        // Result handshake and start in the same cycle: no bubble.
        sb_a.push_back(exp_t'{a24(4), 1'b0});
        sb_a.push_back(exp_t'{a24(-32), 1'b0});
        start_a();
        for (int i = 0; i < 4; i++) send_a(1);
        bus_a.out_ready = 1'b1;
        bus_a.start     = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        bus_a.start     = 1'b0;
        chk("b2b_in_ready",  {31'b0, bus_a.in_ready},  32'd1);
        chk("b2b_out_valid", {31'b0, bus_a.out_valid}, 32'd0);
        for (int i = 0; i < 4; i++) send_a(-8);
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;

        // Asynchronous reset mid-sequence discards the partial sum.
        start_a();
        send_a(50);
        send_a(60);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_acc",  {8'b0, bus_a.out_acc},    32'd0);
        chk("arst_in_ready", {31'b0, bus_a.in_ready},  32'd0);
        chk("arst_busy",     {31'b0, bus_a.busy},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        sb_a.push_back(exp_t'{a24(10), 1'b0});
        bus_a.out_ready = 1'b1;
        start_a();
        send_a(1);
        send_a(2);
        send_a(3);
        send_a(4);
        repeat (3) @(posedge clk);
        #1;

        chk("a_sb_drained", sb_a.size(), 32'd0);
        chk("b_sb_drained", sb_b.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
